// File: rtl/pos_sweep_if.sv
// pos_sweep_if: control and result bus of pos_sweep_ctrl.
//   start/abort      : sweep control from the master
//   busy/done        : sweep status (done is a one-cycle pulse)
//   tt1/tt2          : captured S1/S2 truth tables
//   mis_cnt/first_bad: disagreement count and lowest disagreeing vector
//   equiv            : both forms agree (valid from the done pulse onwards)
//   exp_tt/exp_err   : expected S1 table and its error flag, only with POS_SWEEP_EXPECT_EN
interface pos_sweep_if;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        equiv;
    logic [15:0] tt1;
    logic [15:0] tt2;
    logic [4:0]  mis_cnt;
    logic [3:0]  first_bad;
`ifdef POS_SWEEP_EXPECT_EN
    logic [15:0] exp_tt;
    logic        exp_err;
    modport master (output start, abort, exp_tt,
                    input busy, done, equiv, tt1, tt2, mis_cnt, first_bad, exp_err);
    modport slave  (input start, abort, exp_tt,
                    output busy, done, equiv, tt1, tt2, mis_cnt, first_bad, exp_err);
`else
    modport master (output start, abort,
                    input busy, done, equiv, tt1, tt2, mis_cnt, first_bad);
    modport slave  (input start, abort,
                    output busy, done, equiv, tt1, tt2, mis_cnt, first_bad);
`endif
endinterface

// File: rtl/pos_sweep_ctrl.sv
// pos_sweep_ctrl: sweeps X/Y/W/Z through vectors 0..15, captures S1/S2 truth tables and checks equivalence.
//   clk, rst_n         : clock, asynchronous active-low reset
//   ctl (slave)        : control/result bus, see pos_sweep_if
//   x_o, y_o, w_o, z_o : vector to the function units, x_o is the MSB
//   s1_i, s2_i         : reference-form and simplified-form outputs
//   SETTLE             : cycles each vector is held before sampling (1..15)
//   Optional macro POS_SWEEP_EXPECT_EN adds an expected-S1 table check.
module pos_sweep_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    pos_sweep_if.slave ctl,
    output logic x_o,
    output logic y_o,
    output logic w_o,
    output logic z_o,
    input  logic s1_i,
    input  logic s2_i
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;
    localparam logic [3:0] WLAST = 4'(SETTLE - 1);
    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d, wcnt_q, wcnt_d, fb_q, fb_d;
    logic [15:0] tt1_q, tt1_d, tt2_q, tt2_d;
    logic [4:0]  mis_q, mis_d;
    logic        eq_q, eq_d, err_n;
`ifdef POS_SWEEP_EXPECT_EN
    logic [15:0] exp_q, exp_d;
    logic        err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // abort beats both start (in IDLE) and the capture (in SAMPLE)
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = (ctl.start && !ctl.abort) ? S_WAIT : S_IDLE;
            S_WAIT:   state_d = ctl.abort ? S_IDLE : (wcnt_q == WLAST) ? S_SAMPLE : S_WAIT;
            S_SAMPLE: state_d = ctl.abort ? S_IDLE : (idx_q == 4'd15) ? S_DONE : S_WAIT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ctl.busy = (state_q == S_WAIT) || (state_q == S_SAMPLE);
        ctl.done = (state_q == S_DONE);
    end

    always_comb begin
        idx_d  = idx_q;
        wcnt_d = wcnt_q;
        fb_d   = fb_q;
        tt1_d  = tt1_q;
        tt2_d  = tt2_q;
        mis_d  = mis_q;
        eq_d   = eq_q;
`ifdef POS_SWEEP_EXPECT_EN
        exp_d  = exp_q;
        err_d  = err_q;
`endif
        if (state_q == S_IDLE && state_d == S_WAIT) begin
            idx_d  = '0;
            wcnt_d = '0;
            fb_d   = '0;
            tt1_d  = '0;
            tt2_d  = '0;
            mis_d  = '0;
            eq_d   = 1'b0;
`ifdef POS_SWEEP_EXPECT_EN
            exp_d  = ctl.exp_tt;
            err_d  = 1'b0;
`endif
        end
        if (state_q == S_WAIT && state_d == S_WAIT) wcnt_d = wcnt_q + 4'd1;
        if (state_q == S_SAMPLE && !ctl.abort) begin
            tt1_d[idx_q] = s1_i;
            tt2_d[idx_q] = s2_i;
            if (s1_i != s2_i) mis_d = mis_q + 5'd1;
            if (s1_i != s2_i && mis_q == 5'd0) fb_d = idx_q;
`ifdef POS_SWEEP_EXPECT_EN
            if (s1_i != exp_q[idx_q]) err_d = 1'b1;
`endif
            if (state_d == S_WAIT) begin
                idx_d  = idx_q + 4'd1;
                wcnt_d = '0;
            end
        end
        if (state_d == S_IDLE) idx_d = '0;
        // equiv is settled on the edge into DONE so it is valid with the done pulse
        if (state_d == S_DONE) eq_d = (mis_d == 5'd0) && !err_n;
    end

`ifdef POS_SWEEP_EXPECT_EN
    assign err_n       = err_d;
    assign ctl.exp_err = err_q;
`else
    assign err_n = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            wcnt_q <= '0;
            fb_q   <= '0;
            tt1_q  <= '0;
            tt2_q  <= '0;
            mis_q  <= '0;
            eq_q   <= 1'b0;
`ifdef POS_SWEEP_EXPECT_EN
            exp_q  <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            idx_q  <= idx_d;
            wcnt_q <= wcnt_d;
            fb_q   <= fb_d;
            tt1_q  <= tt1_d;
            tt2_q  <= tt2_d;
            mis_q  <= mis_d;
            eq_q   <= eq_d;
`ifdef POS_SWEEP_EXPECT_EN
            exp_q  <= exp_d;
            err_q  <= err_d;
`endif
        end
    end

    assign {x_o, y_o, w_o, z_o} = idx_q;
    assign ctl.tt1       = tt1_q;
    assign ctl.tt2       = tt2_q;
    assign ctl.mis_cnt   = mis_q;
    assign ctl.first_bad = fb_q;
    assign ctl.equiv     = eq_q;
endmodule
